multicycle_sequencer: RTL and testbench

- Multi-cycle control FSM for the RISC-V core.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared single-port memory with a ready handshake.
- Drives the datapath strobes: PC, IR, ALU, register file and memory.
- Sits beside the datapath in place of a single-cycle decoder. Adds a memory-timeout watchdog, fault reporting and a retired-instruction counter.

---
 rtl/multicycle_sequencer.sv | 172 +++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB over a shared single-port memory,
// with a memory-timeout watchdog, sticky fault reporting and a retired-instruction counter.
module multicycle_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 clear_fault,
    input  logic [6:0]           opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 mem_addr_sel,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic [1:0]           alu_op,
    output logic                 alu_src,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic                 busy,
    output logic                 fault,
    output logic [1:0]           fault_code,
    output logic [INSTRET_W-1:0] instret
);

    localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExec, StMem, StWb, StFault
    } state_e;

    typedef enum logic [1:0] {ClsR, ClsLoad, ClsStore, ClsBranch} cls_e;

    state_e               state_q, state_d;
    cls_e                 cls_q, cls_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [1:0]           fc_q, fc_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic                 retire;
    logic                 tmo_limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cls_q     <= ClsR;
            tmo_q     <= '0;
            fc_q      <= 2'b00;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            tmo_q     <= tmo_d;
            fc_q      <= fc_d;
            instret_q <= instret_d;
        end
    end

    // The cycle that would be number MEM_TIMEOUT of waiting faults unless ready arrives.
    assign tmo_limit = (tmo_q == TW'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        tmo_d        = '0;
        fc_d         = fc_q;
        instret_d    = instret_q;
        retire       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        alu_op       = 2'b00;
        alu_src      = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        busy         = (state_q != StIdle);
        fault        = (state_q == StFault);
        fault_code   = fc_q;

        case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end else if (tmo_limit) begin
                    state_d = StFault;
                    fc_d    = 2'b01;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            StDecode: begin
                state_d = StExec;
                case (opcode)
                    7'b0110011: cls_d = ClsR;
                    7'b0000011: cls_d = ClsLoad;
                    7'b0100011: cls_d = ClsStore;
                    7'b1100011: cls_d = ClsBranch;
                    default: begin
                        state_d = StFault;
                        fc_d    = 2'b11;
                    end
                endcase
            end
            StExec: begin
                unique case (cls_q)
                    ClsR: begin
                        alu_op  = 2'b10;
                        state_d = StWb;
                    end
                    ClsLoad, ClsStore: begin
                        alu_src = 1'b1;
                        state_d = StMem;
                    end
                    ClsBranch: begin
                        alu_op   = 2'b01;
                        pc_write = zero;
                        pc_src   = zero;
                        retire   = 1'b1;
                    end
                endcase
            end
            StMem: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (cls_q == ClsStore);
                alu_src      = 1'b1;
                if (mem_ready) begin
                    if (cls_q == ClsStore) retire = 1'b1;
                    else state_d = StWb;
                end else if (tmo_limit) begin
                    state_d = StFault;
                    fc_d    = 2'b10;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            StWb: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls_q == ClsLoad);
                retire     = 1'b1;
            end
            StFault: begin
                if (clear_fault) begin
                    state_d = StIdle;
                    fc_d    = 2'b00;
                end
            end
            default: state_d = StIdle;
        endcase

        // Instruction boundary: run is only consulted here, so in-flight work always completes.
        if (retire) begin
            instret_d = instret_q + INSTRET_W'(1);
            state_d   = run ? StFetch : StIdle;
        end
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: a per-cycle vector table for the instruction
// classes, then hand-written sequences for timeouts, illegal opcodes, run drop and async reset.
module tb_multicycle_sequencer;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_IL = 7'b1111111;

    // {mem_req,mem_we,mem_addr_sel}_{ir_write,pc_write,pc_src}_{alu_op}
    // _{alu_src,reg_write,mem_to_reg}_{busy,fault}_{fault_code}
    localparam logic [14:0] O_IDLE     = 15'b000_000_00_000_00_00;
    localparam logic [14:0] O_FETCH_RD = 15'b100_110_00_000_10_00;
    localparam logic [14:0] O_FETCH_WT = 15'b100_000_00_000_10_00;
    localparam logic [14:0] O_DEC      = 15'b000_000_00_000_10_00;
    localparam logic [14:0] O_EXEC_R   = 15'b000_000_10_000_10_00;
    localparam logic [14:0] O_EXEC_LS  = 15'b000_000_00_100_10_00;
    localparam logic [14:0] O_MEM_LD   = 15'b101_000_00_100_10_00;
    localparam logic [14:0] O_MEM_ST   = 15'b111_000_00_100_10_00;
    localparam logic [14:0] O_WB_R     = 15'b000_000_00_010_10_00;
    localparam logic [14:0] O_WB_LD    = 15'b000_000_00_011_10_00;
    localparam logic [14:0] O_EXEC_BT  = 15'b000_011_01_000_10_00;
    localparam logic [14:0] O_EXEC_BN  = 15'b000_000_01_000_10_00;
    localparam logic [14:0] O_FAULT_01 = 15'b000_000_00_000_11_01;
    localparam logic [14:0] O_FAULT_11 = 15'b000_000_00_000_11_11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        clear_fault = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src;
    logic [1:0]  alu_op;
    logic        alu_src, reg_write, mem_to_reg, busy, fault;
    logic [1:0]  fault_code;
    logic [31:0] instret;
    logic [14:0] act;

    int checks = 0;
    int errors = 0;

    multicycle_sequencer #(
        .MEM_TIMEOUT(16),
        .INSTRET_W  (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .clear_fault (clear_fault),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr_sel(mem_addr_sel),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .alu_op      (alu_op),
        .alu_src     (alu_src),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .busy        (busy),
        .fault       (fault),
        .fault_code  (fault_code),
        .instret     (instret)
    );

    assign act = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_op,
                  alu_src, reg_write, mem_to_reg, busy, fault, fault_code};

    always #5 clk = ~clk;

    typedef struct {
        logic        run;
        logic [6:0]  op;
        logic        zero;
        logic        rdy;
        logic [14:0] exp;
        int unsigned ret;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [6:0] op, input logic z, input logic rdy,
                       input logic [14:0] exp, input int unsigned ret, input string name);
        vec_t v;
        v.run = r; v.op = op; v.zero = z; v.rdy = rdy; v.exp = exp; v.ret = ret; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        add(0, OP_R,  0, 1, O_IDLE,     0, "idle_hold");
        add(1, OP_R,  0, 1, O_IDLE,     0, "idle_go");
        add(1, OP_R,  0, 1, O_FETCH_RD, 0, "r_fetch");
        add(1, OP_R,  0, 1, O_DEC,      0, "r_dec");
        add(1, OP_R,  0, 1, O_EXEC_R,   0, "r_exec");
        add(1, OP_R,  0, 1, O_WB_R,     0, "r_wb");
        add(1, OP_LD, 0, 1, O_FETCH_RD, 1, "ld_fetch");
        add(1, OP_LD, 0, 1, O_DEC,      1, "ld_dec");
        add(1, OP_LD, 0, 1, O_EXEC_LS,  1, "ld_exec");
        add(1, OP_LD, 0, 0, O_MEM_LD,   1, "ld_mem_w0");
        add(1, OP_LD, 0, 0, O_MEM_LD,   1, "ld_mem_w1");
        add(1, OP_LD, 0, 0, O_MEM_LD,   1, "ld_mem_w2");
        add(1, OP_LD, 0, 1, O_MEM_LD,   1, "ld_mem_rdy");
        add(1, OP_LD, 0, 1, O_WB_LD,    1, "ld_wb");
        add(1, OP_ST, 0, 1, O_FETCH_RD, 2, "st_fetch");
        add(1, OP_ST, 0, 1, O_DEC,      2, "st_dec");
        add(1, OP_ST, 0, 1, O_EXEC_LS,  2, "st_exec");
        add(1, OP_ST, 0, 1, O_MEM_ST,   2, "st_mem");
        add(1, OP_BR, 1, 1, O_FETCH_RD, 3, "bt_fetch");
        add(1, OP_BR, 1, 1, O_DEC,      3, "bt_dec");
        add(1, OP_BR, 1, 1, O_EXEC_BT,  3, "bt_exec");
        add(1, OP_BR, 0, 1, O_FETCH_RD, 4, "bn_fetch");
        add(1, OP_BR, 0, 1, O_DEC,      4, "bn_dec");
        add(1, OP_BR, 0, 1, O_EXEC_BN,  4, "bn_exec");
        add(1, OP_R,  0, 0, O_FETCH_WT, 5, "next_fetch");

        do_reset();
        chk("reset_outputs", act, O_IDLE);
        chk("reset_instret", instret, 0);

        foreach (vecs[i]) begin
            run = vecs[i].run; opcode = vecs[i].op; zero = vecs[i].zero;
            mem_ready = vecs[i].rdy;
            #1;
            chk(vecs[i].name, act, vecs[i].exp);
            chk({vecs[i].name, "_instret"}, instret, vecs[i].ret);
            tick();
        end

        // Fetch timeout: 16 waiting cycles then FAULT/01; run ignored; clear returns to IDLE.
        do_reset();
        run = 1'b1; opcode = OP_R; mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("fetch_wait%0d", i), act, O_FETCH_WT);
            tick();
        end
        chk("fetch_timeout", act, O_FAULT_01);
        run = 1'b0;
        tick();
        chk("fault_run0", act, O_FAULT_01);
        run = 1'b1;
        tick();
        chk("fault_run1", act, O_FAULT_01);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("fault_cleared", act, O_IDLE);

        // Ready on the limit cycle wins; then an illegal opcode faults with code 11.
        do_reset();
        run = 1'b1; opcode = OP_IL; mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) tick();
        mem_ready = 1'b1;
        #1;
        chk("ready_wins", act, O_FETCH_RD);
        tick();
        chk("illegal_dec", act, O_DEC);
        tick();
        chk("illegal_fault", act, O_FAULT_11);
        run = 1'b0;
        tick();
        chk("illegal_run0", act, O_FAULT_11);
        run = 1'b1;
        tick();
        chk("illegal_run1", act, O_FAULT_11);
        run = 1'b0;
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("illegal_cleared", act, O_IDLE);
        chk("illegal_instret", instret, 0);

        // run dropped during EXEC of a LOAD: completes through WB, then IDLE.
        do_reset();
        run = 1'b1; opcode = OP_LD; mem_ready = 1'b1;
        tick();
        tick();
        tick();
        run = 1'b0;
        #1;
        chk("drop_exec", act, O_EXEC_LS);
        tick();
        chk("drop_mem", act, O_MEM_LD);
        tick();
        chk("drop_wb", act, O_WB_LD);
        tick();
        chk("drop_idle", act, O_IDLE);
        chk("drop_instret", instret, 1);
        tick();
        chk("drop_stays_idle", act, O_IDLE);

        // Async reset mid-MEM clears everything without a clock edge.
        run = 1'b1;
        tick();
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        chk("pre_reset_mem", act, O_MEM_LD);
        chk("pre_reset_instret", instret, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", act, O_IDLE);
        chk("async_reset_instret", instret, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
